// File: rtl/redirect_ctrl_pkg.sv
// rtl/redirect_ctrl_pkg.sv - shared next-PC operation, branch funct3 and FSM state encodings
package redirect_ctrl_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_STOP   = 3'b011;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        RC_RUN   = 2'd0,
        RC_FLUSH = 2'd1,
        RC_HALT  = 2'd2
    } rc_state_t;

endpackage

// File: rtl/redirect_ctrl_branch_cmp.sv
// rtl/redirect_ctrl_branch_cmp.sv - combinational RV32I branch condition evaluator
module branch_cmp
    import redirect_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken,
    output logic        illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = ($signed(rs1) < $signed(rs2));
            BGE:     taken = ($signed(rs1) >= $signed(rs2));
            BLTU:    taken = (rs1 < rs2);
            BGEU:    taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/redirect_ctrl.sv
// rtl/redirect_ctrl.sv - EX-stage control-transfer resolver driving next-PC, flush/hold and counters
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic             ex_halt,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    input  logic             id_stall,
    input  logic             resume,
    output logic [2:0]       npc_op,
    output logic             pc_we,
    output logic             hold_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             illegal_br,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    rc_state_t state, state_next;
    logic      br_taken, br_illegal;
    logic      redirect;
    logic      illegal_next;

    branch_cmp u_branch_cmp (
        .funct3  (ex_funct3),
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= RC_RUN;
            redirect_cnt <= '0;
            stall_cnt    <= '0;
            illegal_br   <= 1'b0;
        end else begin
            state      <= state_next;
            illegal_br <= illegal_next;
            if (redirect)
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            if (!pc_we)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        npc_op       = NPC_PLUS4;
        pc_we        = 1'b1;
        hold_if_id   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        halted       = 1'b0;
        redirect     = 1'b0;
        illegal_next = 1'b0;
        state_next   = state;

        if (!rstn) begin
            npc_op      = NPC_STOP;
            pc_we       = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            state_next  = RC_RUN;
        end else begin
            case (state)
                RC_RUN: begin
                    // A redirect squashes the instruction in ID, so a concurrent stall is moot
                    if (ex_valid && ex_halt) begin
                        npc_op      = NPC_STOP;
                        pc_we       = 1'b0;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        state_next  = RC_HALT;
                    end else if (ex_valid && (ex_jalr || ex_jal || (ex_branch && br_taken))) begin
                        npc_op      = ex_jalr ? NPC_JALR : (ex_jal ? NPC_JUMP : NPC_BRANCH);
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        redirect    = 1'b1;
                        state_next  = RC_FLUSH;
                    end else if (id_stall) begin
                        npc_op      = NPC_STOP;
                        pc_we       = 1'b0;
                        hold_if_id  = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                    illegal_next = ex_valid && ex_branch && br_illegal
                                   && !ex_halt && !ex_jalr && !ex_jal;
                end
                RC_FLUSH: begin
                    state_next = RC_RUN;
                    if (id_stall) begin
                        npc_op      = NPC_STOP;
                        pc_we       = 1'b0;
                        hold_if_id  = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                RC_HALT: begin
                    npc_op     = NPC_STOP;
                    pc_we      = 1'b0;
                    hold_if_id = 1'b1;
                    halted     = 1'b1;
                    if (resume)
                        state_next = RC_RUN;
                end
                default: state_next = RC_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb/tb_redirect_ctrl.sv - directed plus randomized check of redirect_ctrl against a behavioural model
module tb_redirect_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rstn, ex_valid, ex_branch, ex_jal, ex_jalr, ex_halt, id_stall, resume;
    logic [2:0]    ex_funct3;
    logic [31:0]   ex_rs1, ex_rs2;
    logic [2:0]    npc_op;
    logic          pc_we, hold_if_id, flush_if_id, flush_id_ex, halted, illegal_br;
    logic [CW-1:0] redirect_cnt, stall_cnt;

    int passed = 0;
    int total  = 0;

    // model: mode 0 = running, 1 = one squash cycle, 2 = halted
    int m_mode  = 0;
    int m_redir = 0;
    int m_stall = 0;
    int m_ill   = 0;

    always #5 clk = ~clk;

    redirect_ctrl #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_jal       (ex_jal),
        .ex_jalr      (ex_jalr),
        .ex_halt      (ex_halt),
        .ex_funct3    (ex_funct3),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .id_stall     (id_stall),
        .resume       (resume),
        .npc_op       (npc_op),
        .pc_we        (pc_we),
        .hold_if_id   (hold_if_id),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .halted       (halted),
        .illegal_br   (illegal_br),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit cond_taken(input int f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        case (f3)
            0: return ua == ub;
            1: return ua != ub;
            4: return sa < sb;
            5: return sa >= sb;
            6: return ua < ub;
            7: return ua >= ub;
            default: return 0;
        endcase
    endfunction

    // One cycle: drive at negedge, check combinational and registered outputs, then advance the model
    task automatic step(input bit rst_n, input bit v, input bit br, input bit j, input bit jr,
                        input bit h, input int f3, input logic [31:0] a, input logic [31:0] b,
                        input bit st, input bit res);
        int e_op = 0, e_we = 1, e_hold = 0, e_fi = 0, e_fe = 0, e_hlt = 0;
        int nxt = m_mode;
        bit redir = 0;
        bit ill = 0;
        @(negedge clk);
        rstn = rst_n; ex_valid = v; ex_branch = br; ex_jal = j; ex_jalr = jr; ex_halt = h;
        ex_funct3 = 3'(f3); ex_rs1 = a; ex_rs2 = b; id_stall = st; resume = res;
        #1;
        if (!rst_n) begin
            e_op = 3; e_we = 0; e_fi = 1; e_fe = 1;
        end else if (m_mode == 2) begin
            e_op = 3; e_we = 0; e_hold = 1; e_hlt = 1;
            if (res) nxt = 0;
        end else if (m_mode == 0 && v && h) begin
            e_op = 3; e_we = 0; e_fi = 1; e_fe = 1; nxt = 2;
        end else if (m_mode == 0 && v && (jr || j || (br && cond_taken(f3, a, b)))) begin
            e_op = jr ? 4 : (j ? 2 : 1); e_fi = 1; e_fe = 1; redir = 1; nxt = 1;
        end else begin
            if (st) begin
                e_op = 3; e_we = 0; e_hold = 1; e_fe = 1;
            end
            nxt = 0;
        end
        if (rst_n && m_mode == 0 && v && br && !h && !j && !jr && (f3 == 2 || f3 == 3))
            ill = 1;

        chk("npc_op", 32'(npc_op), 32'(e_op));
        chk("pc_we", 32'(pc_we), 32'(e_we));
        chk("hold_if_id", 32'(hold_if_id), 32'(e_hold));
        chk("flush_if_id", 32'(flush_if_id), 32'(e_fi));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(e_fe));
        chk("halted", 32'(halted), 32'(e_hlt));
        chk("illegal_br", 32'(illegal_br), 32'(m_ill));
        chk("redirect_cnt", 32'(redirect_cnt), 32'(m_redir));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));

        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_redir = 0; m_stall = 0; m_ill = 0;
        end else begin
            m_mode  = nxt;
            m_ill   = int'(ill);
            m_redir = (m_redir + int'(redir)) % (1 << CW);
            m_stall = (m_stall + (e_we == 0 ? 1 : 0)) % (1 << CW);
        end
    endtask

    task automatic idle(input bit st, input bit res);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, st, res);
    endtask

    initial begin
        // reset, then idle running
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        repeat (4) idle(0, 0);

        // BEQ taken, then the squash cycle
        step(1, 1, 1, 0, 0, 0, 0, 32'h5, 32'h5, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 32'h5, 32'h5, 0, 0);
        // BLT signed taken, BLTU same operands not taken
        step(1, 1, 1, 0, 0, 0, 4, 32'hFFFF_FFFF, 32'h1, 0, 0);
        idle(0, 0);
        step(1, 1, 1, 0, 0, 0, 6, 32'hFFFF_FFFF, 32'h1, 0, 0);
        // JALR with a coincident stall; stall honoured in the squash cycle
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // two stall cycles
        idle(1, 0);
        idle(1, 0);
        idle(0, 0);
        // illegal funct3 branch: not taken, flag next cycle
        step(1, 1, 1, 0, 0, 0, 2, 32'h7, 32'h7, 0, 0);
        step(1, 1, 1, 0, 0, 0, 3, 32'h7, 32'h9, 0, 0);
        idle(0, 0);
        // ECALL, held halt ignoring EX, resume, then PLUS4
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        idle(0, 0);
        idle(0, 1);
        idle(0, 0);
        idle(0, 1);
        // halt again, then reset while halted
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) idle(0, 0);

        // randomized traffic, including overlapping flags and occasional reset
        for (int i = 0; i < 600; i++) begin
            int          r  = int'($urandom_range(0, 15));
            bit          v  = ($urandom_range(0, 3) != 0);
            bit          h  = (r == 0);
            bit          jr = (r == 1);
            bit          j  = (r == 2);
            bit          br = (r >= 3 && r <= 9);
            logic [31:0] a  = $urandom;
            logic [31:0] b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) begin
                h = 1'($urandom); jr = 1'($urandom); j = 1'($urandom); br = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0) b = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, a[30:0]};
            step(($urandom_range(0, 59) != 0), v, br, j, jr, h, int'($urandom_range(0, 7)),
                 a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
